// File: rtl/imm_gen_if.sv
// Handshake and data bundle for imm_gen: instruction side in, immediate side out.
interface imm_gen_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       ImmSrc;
  logic [31:0]      instr;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  ImmOp;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  // Decode stage / bench side: drives instructions, consumes immediates.
  modport master (
    output in_valid, ImmSrc, instr, in_tag, flush, out_ready,
    input  in_ready, out_valid, ImmOp, out_tag, out_illegal
  );

  // Immediate generator side.
  modport slave (
    input  in_valid, ImmSrc, instr, in_tag, flush, out_ready,
    output in_ready, out_valid, ImmOp, out_tag, out_illegal
  );
endinterface

// File: rtl/imm_gen.sv
// Registered RV32I/RV64I immediate generator with a 2-entry skid-buffered
// valid/ready output stage. XLEN must be 32 or 64.
module imm_gen #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  imm_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             in_ready_q;

  logic [XLEN-1:0]  out_imm_q, skid_imm_q;
  logic [TAG_W-1:0] out_tag_q, skid_tag_q;
  logic             out_ill_q, skid_ill_q;

  logic [31:0]      ir;
  logic [31:0]      raw32;
  logic             sext;
  logic [XLEN-1:0]  dec_imm;
  logic             dec_ill;

  logic             accept, drain;
  logic             load_out_new, load_out_skid, load_skid;

  // Opcode bits play no part in any immediate format.
  logic             unused_opcode;
  assign unused_opcode = ^bus.instr[6:0];

  assign ir = bus.instr;

  // Combinational decode into a 32-bit value, then sign- or zero-extend to XLEN.
  always_comb begin
    raw32   = '0;
    sext    = 1'b1;
    dec_ill = 1'b0;
    case (bus.ImmSrc)
      3'b000: raw32 = {{20{ir[31]}}, ir[31:20]};
      3'b001: raw32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      3'b010: raw32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      3'b011: raw32 = {ir[31:12], 12'b0};
      3'b100: raw32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      3'b101: begin
        sext = 1'b0;
        if (XLEN == 64) begin
          raw32 = {26'b0, ir[25:20]};
        end else if (ir[25]) begin
          dec_ill = 1'b1;
        end else begin
          raw32 = {27'b0, ir[24:20]};
        end
      end
      3'b110: begin
        sext  = 1'b0;
        raw32 = {27'b0, ir[19:15]};
      end
      default: dec_ill = 1'b1;
    endcase
    dec_imm = sext ? XLEN'($signed(raw32)) : XLEN'(raw32);
  end

  assign accept = bus.in_valid & in_ready_q;
  assign drain  = (state_q != EMPTY) & bus.out_ready;

  // Next-state and load selects; flush overrides drain and accept.
  always_comb begin
    state_d       = state_q;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d      = ONE;
            load_out_new = 1'b1;
          end
        end
        ONE: begin
          if (drain && accept) begin
            load_out_new = 1'b1;
          end else if (drain) begin
            state_d = EMPTY;
          end else if (accept) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end
        end
        FULL: begin
          if (drain) begin
            state_d       = ONE;
            load_out_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State register; in_ready is registered from the next state only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  // Output and skid data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_imm_q  <= '0;
      out_tag_q  <= '0;
      out_ill_q  <= 1'b0;
      skid_imm_q <= '0;
      skid_tag_q <= '0;
      skid_ill_q <= 1'b0;
    end else begin
      if (load_out_new) begin
        out_imm_q <= dec_imm;
        out_tag_q <= bus.in_tag;
        out_ill_q <= dec_ill;
      end else if (load_out_skid) begin
        out_imm_q <= skid_imm_q;
        out_tag_q <= skid_tag_q;
        out_ill_q <= skid_ill_q;
      end
      if (load_skid) begin
        skid_imm_q <= dec_imm;
        skid_tag_q <= bus.in_tag;
        skid_ill_q <= dec_ill;
      end
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = (state_q != EMPTY);
  assign bus.ImmOp       = out_imm_q;
  assign bus.out_tag     = out_tag_q;
  assign bus.out_illegal = out_ill_q;

endmodule

// File: tb/tb_imm_gen.sv
// Bench for imm_gen: XLEN=32 and XLEN=64 instances driven in lockstep,
// table of hand-decoded vectors, queue scoreboard, plus stall/flush/reset sequences.
module tb_imm_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, flush, out_ready;
  logic [2:0]  ImmSrc;
  logic [31:0] instr;
  logic [31:0] in_tag;

  always #5 clk = ~clk;

  imm_gen_if #(.XLEN(32), .TAG_W(32)) b32 ();
  imm_gen_if #(.XLEN(64), .TAG_W(32)) b64 ();

  assign b32.in_valid  = in_valid;
  assign b32.ImmSrc    = ImmSrc;
  assign b32.instr     = instr;
  assign b32.in_tag    = in_tag;
  assign b32.flush     = flush;
  assign b32.out_ready = out_ready;
  assign b64.in_valid  = in_valid;
  assign b64.ImmSrc    = ImmSrc;
  assign b64.instr     = instr;
  assign b64.in_tag    = in_tag;
  assign b64.flush     = flush;
  assign b64.out_ready = out_ready;

  imm_gen #(.XLEN(32), .TAG_W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  imm_gen #(.XLEN(64), .TAG_W(32)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

  typedef struct {
    logic [2:0]  src;
    logic [31:0] ins;
    logic [31:0] e32;
    logic        i32;
    logic [63:0] e64;
    logic        i64;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] tag;
  } sb_t;

  localparam int NV = 16;
  vec_t vecs[NV];
  sb_t  q32[$];
  sb_t  q64[$];
  int   cur_idx;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: sampled mid-cycle, describes what the next rising edge does.
  always @(negedge clk) begin
    sb_t e;
    if (!rst_n || flush) begin
      q32.delete();
      q64.delete();
    end else begin
      if (b32.out_valid && out_ready) begin
        if (q32.size() == 0) chk("sb32 unexpected out_valid", 64'(b32.out_valid), 64'd0);
        else begin
          e = q32.pop_front();
          chk("sb32 ImmOp", 64'(b32.ImmOp), 64'(vecs[e.idx].e32));
          chk("sb32 out_tag", 64'(b32.out_tag), 64'(e.tag));
          chk("sb32 out_illegal", 64'(b32.out_illegal), 64'(vecs[e.idx].i32));
        end
      end
      if (b64.out_valid && out_ready) begin
        if (q64.size() == 0) chk("sb64 unexpected out_valid", 64'(b64.out_valid), 64'd0);
        else begin
          e = q64.pop_front();
          chk("sb64 ImmOp", b64.ImmOp, vecs[e.idx].e64);
          chk("sb64 out_tag", 64'(b64.out_tag), 64'(e.tag));
          chk("sb64 out_illegal", 64'(b64.out_illegal), 64'(vecs[e.idx].i64));
        end
      end
      if (in_valid && b32.in_ready) begin
        e.idx = cur_idx; e.tag = in_tag; q32.push_back(e);
      end
      if (in_valid && b64.in_ready) begin
        e.idx = cur_idx; e.tag = in_tag; q64.push_back(e);
      end
    end
  end

  task automatic set_vec(input int idx, input logic [31:0] tag);
    cur_idx = idx;
    ImmSrc  = vecs[idx].src;
    instr   = vecs[idx].ins;
    in_tag  = tag;
  endtask

  // Offer one entry and hold it until accepted (bounded).
  task automatic send(input int idx, input logic [31:0] tag);
    int n;
    n = 0;
    set_vec(idx, tag);
    in_valid = 1'b1;
    while (!b32.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) chk("send timeout in_ready", 64'(b32.in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain;
    int n;
    n = 0;
    while ((q32.size() != 0 || q64.size() != 0) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("drain q32 empty", 64'(q32.size()), 64'd0);
    chk("drain q64 empty", 64'(q64.size()), 64'd0);
  endtask

  task automatic chk_reset_vals(input string tagname);
    chk({tagname, " out_valid32"}, 64'(b32.out_valid), 64'd0);
    chk({tagname, " in_ready32"}, 64'(b32.in_ready), 64'd1);
    chk({tagname, " ImmOp32"}, 64'(b32.ImmOp), 64'd0);
    chk({tagname, " out_tag32"}, 64'(b32.out_tag), 64'd0);
    chk({tagname, " out_illegal32"}, 64'(b32.out_illegal), 64'd0);
    chk({tagname, " out_valid64"}, 64'(b64.out_valid), 64'd0);
    chk({tagname, " in_ready64"}, 64'(b64.in_ready), 64'd1);
    chk({tagname, " ImmOp64"}, b64.ImmOp, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    vecs[0]  = '{3'b000, 32'hFFF00093, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1]  = '{3'b001, 32'hFE009EE3, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[2]  = '{3'b100, 32'h001000EF, 32'h00000800, 1'b0, 64'h0000000000000800, 1'b0};
    vecs[3]  = '{3'b011, 32'h800000B7, 32'h80000000, 1'b0, 64'hFFFFFFFF80000000, 1'b0};
    vecs[4]  = '{3'b101, 32'h02000013, 32'h00000000, 1'b1, 64'h0000000000000020, 1'b0};
    vecs[5]  = '{3'b111, 32'h12345678, 32'h00000000, 1'b1, 64'h0000000000000000, 1'b1};
    vecs[6]  = '{3'b010, 32'h00A12423, 32'h00000008, 1'b0, 64'h0000000000000008, 1'b0};
    vecs[7]  = '{3'b010, 32'hFE112E23, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[8]  = '{3'b110, 32'h800F8000, 32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0};
    vecs[9]  = '{3'b101, 32'h01F00013, 32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0};
    vecs[10] = '{3'b101, 32'h03F00013, 32'h00000000, 1'b1, 64'h000000000000003F, 1'b0};
    vecs[11] = '{3'b000, 32'h7FF00013, 32'h000007FF, 1'b0, 64'h00000000000007FF, 1'b0};
    vecs[12] = '{3'b100, 32'h800000EF, 32'hFFF00000, 1'b0, 64'hFFFFFFFFFFF00000, 1'b0};
    vecs[13] = '{3'b011, 32'h12345037, 32'h12345000, 1'b0, 64'h0000000012345000, 1'b0};
    vecs[14] = '{3'b001, 32'h00000463, 32'h00000008, 1'b0, 64'h0000000000000008, 1'b0};
    vecs[15] = '{3'b001, 32'h000000E3, 32'h00000800, 1'b0, 64'h0000000000000800, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    ImmSrc = 3'b000; instr = '0; in_tag = '0; cur_idx = 0;
    #12;
    chk_reset_vals("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // All vectors back-to-back with out_ready high: one accept per cycle.
    c0 = cyc;
    for (int i = 0; i < NV; i++) send(i, 32'h100 + 32'(i));
    chk("throughput cycles", 64'(cyc - c0), 64'(NV));
    wait_drain();

    // Backpressure: tags 1 and 2 accepted, tag 3 held upstream.
    out_ready = 1'b0;
    set_vec(0, 32'd1); in_valid = 1'b1;
    @(posedge clk); #1;
    chk("bp in_ready after 1st", 64'(b32.in_ready), 64'd1);
    set_vec(1, 32'd2);
    @(posedge clk); #1;
    set_vec(2, 32'd3);
    for (int k = 0; k < 3; k++) begin
      chk("bp in_ready32 low", 64'(b32.in_ready), 64'd0);
      chk("bp in_ready64 low", 64'(b64.in_ready), 64'd0);
      chk("bp stable out_tag", 64'(b32.out_tag), 64'd1);
      chk("bp stable ImmOp32", 64'(b32.ImmOp), 64'(vecs[0].e32));
      chk("bp stable ImmOp64", b64.ImmOp, vecs[0].e64);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    begin
      int n;
      n = 0;
      while (!b32.in_ready && n < 20) begin @(posedge clk); #1; n++; end
      chk("bp in_ready returns", 64'(b32.in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    wait_drain();

    // Flush in FULL together with an offered entry.
    out_ready = 1'b0;
    set_vec(3, 32'h31); in_valid = 1'b1;
    @(posedge clk); #1;
    set_vec(4, 32'h32);
    @(posedge clk); #1;
    chk("fl full in_ready", 64'(b32.in_ready), 64'd0);
    set_vec(5, 32'h33); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("fl out_valid32", 64'(b32.out_valid), 64'd0);
    chk("fl in_ready32", 64'(b32.in_ready), 64'd1);
    chk("fl out_valid64", 64'(b64.out_valid), 64'd0);
    chk("fl in_ready64", 64'(b64.in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("fl nothing emerges", 64'(b32.out_valid), 64'd0);

    // Asynchronous reset while FULL, then first accept after release.
    out_ready = 1'b0;
    set_vec(6, 32'h51); in_valid = 1'b1;
    @(posedge clk); #1;
    set_vec(7, 32'h52);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst pre out_valid", 64'(b32.out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_vals("async rst");
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    set_vec(12, 32'h61); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("post rst out_valid", 64'(b32.out_valid), 64'd1);
    chk("post rst out_tag", 64'(b32.out_tag), 64'h61);
    chk("post rst ImmOp32", 64'(b32.ImmOp), 64'(vecs[12].e32));
    chk("post rst ImmOp64", b64.ImmOp, vecs[12].e64);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
